// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and config legality check for the serial pattern detector
package seq_det_pkg;
  localparam logic [3:0] SEQ_DEF_PAT = 4'b1010;
  localparam int SEQ_DEF_LEN = 4;
  function automatic logic len_legal(input int len, input int max_len);
    return (len >= 2) && (len <= max_len);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector with registered match pulse and saturating counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             x,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);
  localparam logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_DEF_PAT);
  localparam logic [LEN_W-1:0] DEF_LEN = LEN_W'(SEQ_DEF_LEN < PAT_W ? SEQ_DEF_LEN : PAT_W);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);
  logic [PAT_W-1:0] hist, pat_r, nxt, mask;
  logic [LEN_W-1:0] len_r, fill;
  logic             ovl_r, hit, drop;
  always_comb begin
    nxt  = {hist[PAT_W-2:0], x};
    mask = (PAT_W'(1) << len_r) - PAT_W'(1);
    hit  = in_valid && !cfg_load && (fill >= len_r - LEN_W'(1)) && (((nxt ^ pat_r) & mask) == '0);
    drop = hit && !ovl_r;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hist    <= '0;
      fill    <= '0;
      z       <= 1'b0;
      pat_r   <= DEF_PAT;
      len_r   <= DEF_LEN;
      ovl_r   <= 1'b1;
      cfg_err <= 1'b0;
    end else begin
      z <= hit;
      if (cfg_load) begin
        hist <= '0;
        fill <= '0;
        if (len_legal(int'(cfg_len), PAT_W)) begin
          pat_r <= cfg_pattern;
          len_r <= cfg_len;
          ovl_r <= cfg_overlap;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (in_valid) begin
        hist <= drop ? '0 : nxt;
        fill <= drop ? '0 : (fill == FULL ? fill : fill + LEN_W'(1));
      end
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .clr(cnt_clr),
    .cnt(match_cnt)
  );
endmodule
